// File: rtl/pp_accumulator.sv
// pp_accumulator: reduces four signed 34-bit lane products per beat through a
// registered two-level adder tree into a wide accumulator. It returns one 32-bit
// result per job over a valid/ready handshake.
// Optional feature macro: PP_ACC_SAT_EN (saturating result plus overflow flag).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_i; outputs hold the last result
// ST_RUN   | accepting product beats; counts the remaining beats down
// ST_FLUSH | two cycles while the stage-1/stage-2 tree drains
// ST_DONE  | result presented; waits for res_ready_i
module pp_accumulator #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] beats_i,
  input  logic             prod_valid_i,
  output logic             prod_ready_o,
  input  logic [135:0]     partial_prods_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_o,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    flush_q;
  logic                    s1_valid_q;
  logic signed [34:0]      s1_hi_q;
  logic signed [34:0]      s1_lo_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [31:0]             res_q;

  logic signed [33:0]      lane3, lane2, lane1, lane0;
  logic signed [35:0]      s2_sum;
  logic signed [ACC_W-1:0] s2_ext;
  logic                    beat_fire;
  logic                    start_job;
  logic                    start_empty;
  logic                    flush_end;
  logic [31:0]             res_next;
  logic                    ovf_next;

  assign lane3 = partial_prods_i[135:102];
  assign lane2 = partial_prods_i[101:68];
  assign lane1 = partial_prods_i[67:34];
  assign lane0 = partial_prods_i[33:0];

  assign prod_ready_o = (state_q == ST_RUN);
  assign res_valid_o  = (state_q == ST_DONE);
  assign busy_o       = (state_q != ST_IDLE);
  assign res_o        = res_q;

  assign beat_fire   = prod_valid_i && prod_ready_o;
  assign start_job   = (state_q == ST_IDLE) && start_i && (beats_i != '0);
  assign start_empty = (state_q == ST_IDLE) && start_i && (beats_i == '0);
  assign flush_end   = (state_q == ST_FLUSH) && !flush_q;

  // Signed casts sign-extend each operand before the add.
  assign s2_sum = 36'(s1_hi_q) + 36'(s1_lo_q);
  assign s2_ext = ACC_W'(s2_sum);

`ifdef PP_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'(64'sd2147483647);
  localparam logic signed [ACC_W-1:0] RES_MIN = ACC_W'(-64'sd2147483648);
  logic ovf_q;

  // Clamp the accumulator into the signed 32-bit range.
  always_comb begin
    res_next = acc_q[31:0];
    ovf_next = 1'b0;
    if (acc_q > RES_MAX) begin
      res_next = 32'h7FFF_FFFF;
      ovf_next = 1'b1;
    end else if (acc_q < RES_MIN) begin
      res_next = 32'h8000_0000;
      ovf_next = 1'b1;
    end
  end

  // Overflow flag is captured alongside the result and held until the next start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (start_job || start_empty) begin
      ovf_q <= 1'b0;
    end else if (flush_end) begin
      ovf_q <= ovf_next;
    end
  end

  assign overflow_o = ovf_q;
`else
  logic unused_acc_hi;

  // Plain wrap-around: the low word is the result, upper bits are discarded.
  always_comb begin
    res_next = acc_q[31:0];
    ovf_next = 1'b0;
  end

  assign unused_acc_hi = ^{acc_q[ACC_W-1:32], ovf_next};
  assign overflow_o    = 1'b0;
`endif

  // Job sequencing: beat counter and flush timer are down-counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_job) begin
            cnt_q   <= beats_i;
            state_q <= ST_RUN;
          end else if (start_empty) begin
            state_q <= ST_DONE;
          end
        end
        ST_RUN: begin
          if (beat_fire) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              flush_q <= 1'b1;
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_q) flush_q <= 1'b0;
          else         state_q <= ST_DONE;
        end
        default: begin
          if (res_ready_i) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 1: pairwise lane sums, tagged with the beat-accepted bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_hi_q    <= '0;
      s1_lo_q    <= '0;
    end else begin
      s1_valid_q <= beat_fire;
      if (beat_fire) begin
        s1_hi_q <= 35'(lane3) + 35'(lane2);
        s1_lo_q <= 35'(lane1) + 35'(lane0);
      end
    end
  end

  // Stage 2: fold the tree output into the accumulator; bubbles leave it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (start_job || start_empty) begin
      acc_q <= '0;
    end else if (s1_valid_q) begin
      acc_q <= acc_q + s2_ext;
    end
  end

  // Result register: loaded on entry to DONE, held through IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q <= '0;
    end else if (start_job || start_empty) begin
      res_q <= '0;
    end else if (flush_end) begin
      res_q <= res_next;
    end
  end

endmodule
